embalador_garrafas: RTL and testbench
=====================================

// Module: embalador_garrafas
// PURPOSE
//  Consumer end of the bottling line: takes sealed bottles from the sealing stage
//  (one pulse per bottle), buffers them in a stock counter, packs them into boxes of
//  BOX_SIZE, closes each box and hands it to the dispatch conveyor over a valid/ready
//  handshake. It also back-pressures the sealer with stock_full.
// PARAMETERS
//  BOX_SIZE      6    bottles per box (2..15)
//  STOCK_MAX     65   stock capacity in bottles (BOX_SIZE..127)
//  CLOSE_CYCLES  3    cycles spent closing a filled box (>=1)
// PORTS
//  CLK           in   1  line clock; all state changes on rising edge
//  RST           in   1  reset, asynchronous, active-low
//  bottle_in     in   1  one-cycle pulse: one sealed bottle arriving
//  box_ready     in   1  dispatch conveyor can take a box
//  box_valid     out  1  closed box present, held until accepted
//  stock         out  7  bottles waiting in stock
//  box_fill      out  4  bottles currently in the open box
//  stock_full    out  1  stock == STOCK_MAX (combinational from stock reg)
//  reject        out  1  registered pulse: a bottle_in was refused
//  boxes_total   out  8  boxes dispatched since reset, wraps 255->0
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE, stock=0, box_fill=0, boxes_total=0,
//   box_valid=0, reject=0; stock_full=0 follows from stock=0.
//  Accept: bottle_in accepted iff stock < STOCK_MAX. Accepted -> stock+1 next edge.
//   Refused -> stock unchanged, reject=1 for exactly the next cycle.
//  FSM states: IDLE, LOAD, CLOSE, OUT.
//   IDLE : if stock >= BOX_SIZE at the edge -> LOAD (box_fill stays 0).
//   LOAD : every cycle moves one bottle: stock-1, box_fill+1. When box_fill
//          becomes BOX_SIZE -> CLOSE. LOAD lasts exactly BOX_SIZE cycles.
//   CLOSE: counts CLOSE_CYCLES cycles, then -> OUT.
//   OUT  : box_valid=1 (registered, asserted on the first OUT cycle). On
//          box_valid & box_ready: box_fill=0, boxes_total+1, box_valid=0 -> IDLE.
//          No handshake -> stay, box_valid and box_fill held stable.
//  Simultaneous accept + LOAD move in one cycle: stock net unchanged.
//  stock_full is evaluated on the registered stock, so a move in LOAD frees space
//   only from the following cycle (no same-cycle pass-through).
//  Bottles keep being accepted in every state, including CLOSE and OUT.
//  LOAD is entered only with stock >= BOX_SIZE; stock never underflows.
//  Latency: 6 bottles in an empty block (BOX_SIZE=6) -> box_valid rises
//   1 (IDLE->LOAD) + 6 (LOAD) + 3 (CLOSE) = 10 cycles after the edge that
//   registers stock=6.
//  Reset mid-operation: everything returns to reset values immediately; the
//   partially filled box and the stock are discarded (not counted).
//  boxes_total wrap: 255 + 1 -> 0, no flag.
// TESTING
//  1 Reset, 6 bottle_in pulses, box_ready=1 -> LOAD 6 cycles, CLOSE 3, box_valid
//    one cycle, boxes_total=1, stock=0, box_fill=0.
//  2 Box in OUT with box_ready=0 for 20 cycles -> box_valid held 1, box_fill=6;
//    raise box_ready -> accepted in one cycle, back to IDLE.
//  3 box_ready=0, 71 consecutive bottle_in -> stock saturates at 65 at most after
//    the first box's LOAD, stock_full=1, reject pulses for each refused bottle.
//  4 bottle_in held every cycle during LOAD -> stock constant across LOAD cycles,
//    box_fill 0..6.
//  5 Deassert RST during LOAD with box_fill=3, stock=5 -> all outputs to reset
//    values asynchronously; after release, 6 new bottles yield a normal box.
//  6 Dispatch 256 boxes -> boxes_total goes 255 -> 0, block keeps operating.

Source files
------------

// File: rtl/embalador_garrafas.sv
// embalador_garrafas: buffers sealed bottles in a stock counter, packs them into boxes,
// closes each box and hands it to dispatch over a valid/ready handshake.
module embalador_garrafas #(
   parameter int BOX_SIZE     = 6,
   parameter int STOCK_MAX    = 65,
   parameter int CLOSE_CYCLES = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       bottle_in,
   input  logic       box_ready,
   output logic       box_valid,
   output logic [6:0] stock,
   output logic [3:0] box_fill,
   output logic       stock_full,
   output logic       reject,
   output logic [7:0] boxes_total
);
   localparam int CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;
   localparam logic [6:0]    SMAX   = 7'(STOCK_MAX);
   localparam logic [6:0]    BSTOCK = 7'(BOX_SIZE);
   localparam logic [3:0]    BLAST  = 4'(BOX_SIZE - 1);
   localparam logic [CW-1:0] CLAST  = CW'(CLOSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CLOSE, OUT} state_t;

   state_t        state_q, state_d;
   logic [6:0]    stock_q, stock_d;
   logic [3:0]    fill_q, fill_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          reject_q, reject_d;
   logic [7:0]    total_q, total_d;
   logic          accept;

   always_comb begin
      accept   = bottle_in && (stock_q < SMAX);
      reject_d = bottle_in && !accept;
      state_d  = state_q;
      stock_d  = stock_q + {6'd0, accept};
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      total_d  = total_q;
      case (state_q)
         IDLE: if (stock_q >= BSTOCK) state_d = LOAD;
         // an accepted bottle and a moved bottle cancel out in the same cycle
         LOAD: begin
            stock_d = stock_q + {6'd0, accept} - 7'd1;
            fill_d  = fill_q + 4'd1;
            if (fill_q == BLAST) begin
               state_d = CLOSE;
               cnt_d   = '0;
            end
         end
         CLOSE: begin
            if (cnt_q == CLAST) begin
               state_d = OUT;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         OUT: begin
            if (box_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               fill_d  = 4'd0;
               total_d = total_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         stock_q  <= 7'd0;
         fill_q   <= 4'd0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         reject_q <= 1'b0;
         total_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         stock_q  <= stock_d;
         fill_q   <= fill_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         reject_q <= reject_d;
         total_q  <= total_d;
      end
   end

   assign box_valid   = valid_q;
   assign stock       = stock_q;
   assign box_fill    = fill_q;
   assign stock_full  = (stock_q == SMAX);
   assign reject      = reject_q;
   assign boxes_total = total_q;
endmodule

// File: tb/tb_embalador_garrafas.sv
// tb_embalador_garrafas: random and directed stimulus against a countdown-based
// reference model of the packing line.
module tb_embalador_garrafas;
   localparam int B  = 6;
   localparam int SM = 65;
   localparam int C  = 3;

   logic       CLK = 1'b0;
   logic       RST;
   logic       bottle_in;
   logic       box_ready;
   logic       box_valid;
   logic [6:0] stock;
   logic [3:0] box_fill;
   logic       stock_full;
   logic       reject;
   logic [7:0] boxes_total;

   embalador_garrafas #(.BOX_SIZE(B), .STOCK_MAX(SM), .CLOSE_CYCLES(C)) dut (
      .CLK(CLK), .RST(RST), .bottle_in(bottle_in), .box_ready(box_ready),
      .box_valid(box_valid), .stock(stock), .box_fill(box_fill),
      .stock_full(stock_full), .reject(reject), .boxes_total(boxes_total)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // model: a box in progress is a countdown of remaining cycles; the first B
   // ticks each move a bottle, the last C ticks are closing
   int m_stock, m_fill, m_timer, m_total, m_boxes;
   bit m_valid, m_reject;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stock = 0; m_fill = 0; m_timer = 0; m_total = 0;
      m_valid = 0; m_reject = 0;
   endtask

   task automatic model_edge(input bit b, input bit r);
      bit acc;
      acc = b && (m_stock < SM);
      if (m_valid) begin
         if (r) begin
            m_valid = 0;
            m_fill  = 0;
            m_total = (m_total + 1) % 256;
            m_boxes++;
         end
      end else if (m_timer > 0) begin
         if (m_timer > C) begin
            m_stock--;
            m_fill++;
         end
         m_timer--;
         if (m_timer == 0) m_valid = 1;
      end else if (m_stock >= B) begin
         m_timer = B + C;
      end
      m_stock  = m_stock + int'(acc);
      m_reject = b && !acc;
   endtask

   task automatic check_all();
      chk("box_valid", int'(box_valid), int'(m_valid));
      chk("stock", int'(stock), m_stock);
      chk("box_fill", int'(box_fill), m_fill);
      chk("stock_full", int'(stock_full), int'(m_stock == SM));
      chk("reject", int'(reject), int'(m_reject));
      chk("boxes_total", int'(boxes_total), m_total);
   endtask

   task automatic step(input bit b, input bit r);
      bottle_in = b;
      box_ready = r;
      @(posedge CLK);
      model_edge(b, r);
      @(negedge CLK);
      check_all();
   endtask

   initial begin
      int target;
      bit found;
      RST = 1'b0; bottle_in = 1'b0; box_ready = 1'b0;
      m_boxes = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      check_all();
      RST = 1'b1;

      // single box, dispatch ready
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

      // box held in OUT under back-pressure
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

      // stock saturation and rejects
      for (int i = 0; i < 71; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 150; i++) step(1'b0, 1'b1);

      // continuous bottles through LOAD
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

      // asynchronous reset in the middle of LOAD
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         step(1'b1, 1'b1);
         found = (m_timer > C) && (m_fill == 3);
      end
      chk("reach_load_fill3", int'(found), 1);
      #2 RST = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge CLK);
      check_all();
      RST = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1);

      // 256 boxes to wrap the dispatch counter
      target = m_boxes + 256;
      for (int i = 0; i < 20000 && m_boxes < target; i++)
         step(1'b1, $urandom_range(0, 3) != 0);
      chk("wrap_boxes_done", int'(m_boxes >= target), 1);

      // random mix
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
